// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SOF/LEN/payload/CHK frames from the UART receiver and releases
// payload bytes to the consumer only after the whole frame has passed its checks.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF_BYTE   = 8'hA5,
  parameter int         MAX_LEN    = 16,
  parameter int         FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_data_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_endofpacket,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [1:0] LEN_BAD = 2'd0, OVERFLOW = 2'd1, CHK_BAD = 2'd2, GAP = 2'd3;
  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DISCARD} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] rptr_q, cwptr_q, cwptr_d, swptr_q, swptr_d, used;
  logic [8:0] rem_q, rem_d, free;
  logic [7:0] chk_q, chk_d;
  logic ok_q, ok_d, err_q, err_d, we, pop;
  logic [1:0] code_q, code_d;
  logic [15:0] fcnt_q, ecnt_q;
  logic [8:0] mem_q [FIFO_DEPTH];
  assign used = cwptr_q - rptr_q;
  assign free = 9'(FIFO_DEPTH) - 9'(used);
  assign out_valid = rptr_q != cwptr_q;
  assign {out_last, out_data} = mem_q[rptr_q[AW-1:0]];
  assign pop = out_valid && out_ready;
  assign frame_ok = ok_q;
  assign frame_err = err_q;
  assign err_code = code_q;
  assign frame_cnt = fcnt_q;
  assign err_cnt = ecnt_q;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    chk_d = chk_q;
    swptr_d = swptr_q;
    cwptr_d = cwptr_q;
    ok_d = 1'b0;
    err_d = 1'b0;
    code_d = code_q;
    we = 1'b0;
    if (rx_data_ready) begin
      case (state_q)
        HUNT: state_d = rx_data == SOF_BYTE ? LEN : HUNT;
        LEN:
          if (rx_data == 8'd0 || rx_data > MAX_B) begin
            err_d = 1'b1;
            code_d = LEN_BAD;
            state_d = HUNT;
          end else if ({1'b0, rx_data} > free) begin
            err_d = 1'b1;
            code_d = OVERFLOW;
            rem_d = {1'b0, rx_data} + 9'd1;
            state_d = DISCARD;
          end else begin
            rem_d = {1'b0, rx_data};
            chk_d = rx_data;
            swptr_d = cwptr_q;
            state_d = PAYLOAD;
          end
        PAYLOAD: begin
          we = 1'b1;
          swptr_d = swptr_q + PW'(1);
          chk_d = chk_q ^ rx_data;
          rem_d = rem_q - 9'd1;
          state_d = rem_q == 9'd1 ? CHK : PAYLOAD;
        end
        CHK: begin
          ok_d = rx_data == chk_q;
          err_d = rx_data != chk_q;
          code_d = ok_d ? code_q : CHK_BAD;
          cwptr_d = ok_d ? swptr_q : cwptr_q;
          swptr_d = ok_d ? swptr_q : cwptr_q;
          state_d = HUNT;
        end
        DISCARD: begin
          rem_d = rem_q - 9'd1;
          state_d = rem_q == 9'd1 ? HUNT : DISCARD;
        end
        default: state_d = HUNT;
      endcase
    end else if (rx_endofpacket && state_q != HUNT) begin
      // Line went idle mid-frame: drop speculative bytes; a discard just ends quietly
      err_d = state_q != DISCARD;
      code_d = err_d ? GAP : code_q;
      swptr_d = cwptr_q;
      state_d = HUNT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      rptr_q <= '0;
      cwptr_q <= '0;
      swptr_q <= '0;
      rem_q <= '0;
      chk_q <= '0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= '0;
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      state_q <= state_d;
      rptr_q <= rptr_q + PW'(pop);
      cwptr_q <= cwptr_d;
      swptr_q <= swptr_d;
      rem_q <= rem_d;
      chk_q <= chk_d;
      ok_q <= ok_d;
      err_q <= err_d;
      code_q <= code_d;
      fcnt_q <= fcnt_q + 16'(ok_d && fcnt_q != 16'hFFFF);
      ecnt_q <= ecnt_q + 16'(err_d && ecnt_q != 16'hFFFF);
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[swptr_q[AW-1:0]] <= {rem_q == 9'd1, rx_data};
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames; expected bytes/events queued by the stimulus and
// checked by an independent monitor whenever the DUT presents them.
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_data_ready = 1'b0, rx_endofpacket = 1'b0, out_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic out_valid, out_last, frame_ok, frame_err;
  logic [7:0] out_data;
  logic [1:0] err_code;
  logic [15:0] frame_cnt, err_cnt;
  int cmp = 0, bad = 0, fc = 0, ec = 0;
  logic [8:0] bq[$];
  logic [2:0] evq[$];
  logic [7:0] tx[$];
  uart_rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .rx_endofpacket(rx_endofpacket), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (frame_ok && frame_err) chk("ok_err_excl", 1, 0);
    if (frame_ok || frame_err) begin
      if (evq.size() == 0) chk("unexpected_event", {frame_ok, frame_err, err_code}, 0);
      else chk("event", frame_ok ? 3'd4 : {1'b0, err_code}, evq.pop_front());
    end
    if (out_valid && out_ready) begin
      if (bq.size() == 0) chk("unexpected_byte", {out_last, out_data}, 0);
      else chk("byte", {out_last, out_data}, bq.pop_front());
    end
  end
  task automatic send(input logic [7:0] b, input logic e);
    rx_data = b;
    rx_data_ready = 1'b1;
    rx_endofpacket = e;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
    rx_endofpacket = 1'b0;
  endtask
  task automatic flush();
    while (tx.size() > 0) send(tx.pop_front(), 1'b0);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic cnts(input string n);
    idle(2);
    chk({n, "_frame_cnt"}, frame_cnt, fc);
    chk({n, "_err_cnt"}, err_cnt, ec);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    #1 rst = 1'b0;
    idle(1);
    // good 3-byte frame: 03^11^22^33 = 03
    out_ready = 1'b1;
    bq.push_back(9'h011); bq.push_back(9'h022); bq.push_back(9'h133); evq.push_back(3'd4);
    tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    flush();
    fc = 1;
    cnts("good3");
    // bad checksum, then a one-byte good frame (01^7E = 7F)
    evq.push_back(3'd2);
    tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    flush();
    chk("chkbad_no_out", out_valid, 0);
    ec = 1;
    cnts("chkbad");
    chk("chkbad_code", err_code, 2);
    bq.push_back(9'h17E); evq.push_back(3'd4);
    tx = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    flush();
    fc = 2;
    cnts("after_chkbad");
    // LEN 0 and LEN 17 rejected; stray 5A and a HUNT-state gap are ignored
    evq.push_back(3'd0); evq.push_back(3'd0);
    tx = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'h5A};
    flush();
    send(8'h00, 1'b0);
    rx_endofpacket = 1'b1; idle(1); rx_endofpacket = 1'b0;
    ec = 3;
    cnts("lenbad");
    chk("lenbad_code", err_code, 0);
    bq.push_back(9'h17E); evq.push_back(3'd4);
    tx = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    flush();
    fc = 3;
    cnts("after_lenbad");
    // fill all 32 entries with two 16-byte frames (01..10, checksum 00), then overflow
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      tx.push_back(8'hA5); tx.push_back(8'h10);
      for (int i = 1; i <= 16; i++) begin
        tx.push_back(8'(i));
        bq.push_back({i == 16, 8'(i)});
      end
      tx.push_back(8'h00);
      evq.push_back(3'd4);
    end
    flush();
    fc = 5;
    cnts("fill");
    chk("fill_valid", out_valid, 1);
    evq.push_back(3'd1);
    tx = '{8'hA5, 8'h01, 8'hA5, 8'h00};
    flush();
    ec = 4;
    cnts("overflow");
    chk("overflow_code", err_code, 1);
    out_ready = 1'b1;
    for (int n = 0; n < 100 && bq.size() > 0; n++) idle(1);
    chk("drain_empty", bq.size(), 0);
    bq.push_back(9'h142); evq.push_back(3'd4);
    tx = '{8'hA5, 8'h01, 8'h42, 8'h43};
    flush();
    fc = 6;
    cnts("after_drain");
    // gap mid-payload, then gap coinciding with a payload byte
    evq.push_back(3'd3);
    tx = '{8'hA5, 8'h04, 8'h01, 8'h02};
    flush();
    rx_endofpacket = 1'b1; idle(1); rx_endofpacket = 1'b0;
    ec = 5;
    cnts("gap");
    chk("gap_code", err_code, 3);
    chk("gap_no_out", out_valid, 0);
    bq.push_back(9'h010); bq.push_back(9'h120); evq.push_back(3'd4);
    tx = '{8'hA5, 8'h02, 8'h10};
    flush();
    send(8'h20, 1'b1);
    send(8'h32, 1'b0);
    fc = 7;
    cnts("gap_same_cycle");
    // async reset mid-payload with committed bytes unread
    out_ready = 1'b0;
    evq.push_back(3'd4);
    tx = '{8'hA5, 8'h01, 8'h7E, 8'h7F, 8'hA5, 8'h03, 8'h01};
    flush();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_err_code", err_code, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    fc = 0; ec = 0;
    out_ready = 1'b1;
    bq.push_back(9'h155); evq.push_back(3'd4);
    tx = '{8'hA5, 8'h01, 8'h55, 8'h54};
    flush();
    fc = 1;
    cnts("after_rst");
    for (int n = 0; n < 50 && (bq.size() > 0 || evq.size() > 0); n++) idle(1);
    chk("end_bytes_empty", bq.size(), 0);
    chk("end_events_empty", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
